// File: rtl/shli_iterative_pkg.sv
// Shared helpers for the dataflow arithmetic blocks.
// Holds the constant ceil(log2) used to size counters and shift-amount registers.
package shli_iterative_pkg;

  // Ceiling log2 for elaboration-time sizing; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        res = i + 1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/shli_iterative_join.sv
// N-input valid/ready join: the output fires only when every input is valid,
// and each input is told ready only when all the others are valid too.
module join_type #(
  parameter int SIZE = 2
) (
  input  logic [SIZE-1:0] ins_valid,
  output logic [SIZE-1:0] ins_ready,
  output logic            outs_valid,
  input  logic            outs_ready
);

  logic others_s;

  // Join combine: ready for input i needs all other inputs valid and the consumer ready.
  always_comb begin
    ins_ready  = {SIZE{1'b0}};
    outs_valid = &ins_valid;
    others_s   = 1'b1;
    for (int i = 0; i < SIZE; i++) begin
      others_s = 1'b1;
      for (int j = 0; j < SIZE; j++) begin
        if (j != i) begin
          others_s = others_s & ins_valid[j];
        end else begin
          others_s = others_s;
        end
      end
      ins_ready[i] = others_s & outs_ready;
    end
  end

endmodule

// File: rtl/shli_iterative.sv
// Multi-cycle logical left shifter: joins lhs/rhs, then shifts the accumulator
// by at most STEP bits per cycle until the clamped shift amount is consumed.
module shli_iterative
  import shli_iterative_pkg::*;
#(
  parameter int DATA_TYPE = 32,
  parameter int STEP      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_TYPE-1:0] lhs,
  input  logic                 lhs_valid,
  input  logic [DATA_TYPE-1:0] rhs,
  input  logic                 rhs_valid,
  input  logic                 result_ready,
  output logic [DATA_TYPE-1:0] result,
  output logic                 result_valid,
  output logic                 lhs_ready,
  output logic                 rhs_ready
);

  localparam int REM_W = clog2(DATA_TYPE) + 1;

  localparam logic [1:0] IDLE_ENC = 2'd0;
  localparam logic [1:0] BUSY_ENC = 2'd1;
  localparam logic [1:0] DONE_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE_ENC,
    ST_BUSY = BUSY_ENC,
    ST_DONE = DONE_ENC
  } state_t;

  localparam logic [DATA_TYPE-1:0] W_FULL   = DATA_TYPE'(DATA_TYPE);
  localparam logic [REM_W-1:0]     W_REM    = REM_W'(DATA_TYPE);
  localparam logic [REM_W-1:0]     STEP_REM = REM_W'(STEP);
  localparam logic [REM_W-1:0]     REM_ZERO = {REM_W{1'b0}};

  state_t                 state_r, state_n;
  logic [DATA_TYPE-1:0]   acc_r, acc_n;
  logic [REM_W-1:0]       rem_r, rem_n;
  logic [REM_W-1:0]       load_s;
  logic [REM_W-1:0]       step_s;
  logic                   result_valid_r;
  logic                   idle_s;
  logic                   outs_ready_s;
  logic                   accept_s;
  logic [1:0]             join_ready_s;

  assign idle_s       = (state_r == ST_IDLE);
  assign outs_ready_s = idle_s & ~rst;

  join_type #(
    .SIZE (2)
  ) u_join (
    .ins_valid  ({rhs_valid, lhs_valid}),
    .ins_ready  (join_ready_s),
    .outs_valid (accept_s),
    .outs_ready (outs_ready_s)
  );

  assign lhs_ready = join_ready_s[0];
  assign rhs_ready = join_ready_s[1];

  // Every upper bit of rhs takes part in the clamp, so huge amounts become exactly W.
  assign load_s = (rhs >= W_FULL) ? W_REM : rhs[REM_W-1:0];
  assign step_s = (rem_r > STEP_REM) ? STEP_REM : rem_r;

  // Next-state and datapath update for accept, per-cycle bounded shift, and output handshake.
  always_comb begin
    state_n = state_r;
    acc_n   = acc_r;
    rem_n   = rem_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          acc_n   = lhs;
          rem_n   = load_s;
          state_n = (load_s == REM_ZERO) ? ST_DONE : ST_BUSY;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_BUSY: begin
        acc_n = acc_r << step_s;
        rem_n = rem_r - step_s;
        if (rem_n == REM_ZERO) begin
          state_n = ST_DONE;
        end else begin
          state_n = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (result_valid_r && result_ready) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_DONE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        acc_n   = {DATA_TYPE{1'b0}};
        rem_n   = REM_ZERO;
      end
    endcase
  end

  // State, accumulator and remaining-shift registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      acc_r          <= {DATA_TYPE{1'b0}};
      rem_r          <= REM_ZERO;
      result_valid_r <= 1'b0;
    end else begin
      state_r        <= state_n;
      acc_r          <= acc_n;
      rem_r          <= rem_n;
      result_valid_r <= (state_n == ST_DONE);
    end
  end

  assign result       = acc_r;
  assign result_valid = result_valid_r;

endmodule

// File: tb/tb_shli_iterative.sv
// Directed bench for shli_iterative (W=32, STEP=8): latency, value, join,
// backpressure and mid-operation reset, with hand-computed expectations.
module tb_shli_iterative;

  logic        clk;
  logic        rst;
  logic [31:0] lhs;
  logic        lhs_valid;
  logic [31:0] rhs;
  logic        rhs_valid;
  logic        result_ready;
  logic [31:0] result;
  logic        result_valid;
  logic        lhs_ready;
  logic        rhs_ready;

  int vectors;
  int miscompares;

  shli_iterative #(
    .DATA_TYPE (32),
    .STEP      (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .lhs          (lhs),
    .lhs_valid    (lhs_valid),
    .rhs          (rhs),
    .rhs_valid    (rhs_valid),
    .result_ready (result_ready),
    .result       (result),
    .result_valid (result_valid),
    .lhs_ready    (lhs_ready),
    .rhs_ready    (rhs_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Launch one operation with result_ready high; measure cycles from accept edge to result_valid.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    lhs = a; rhs = b; lhs_valid = 1'b1; rhs_valid = 1'b1; result_ready = 1'b1;
    #1;
    check({tag, "_ready"}, {30'd0, rhs_ready, lhs_ready}, 32'h0000_0003);
    tick();
    lhs_valid = 1'b0; rhs_valid = 1'b0;
    lat = 1;
    while (!result_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_val"}, result, exp);
    tick();
    check({tag, "_drop"}, {31'd0, result_valid}, 32'd0);
  endtask

  initial begin
    int lat;
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    lhs = 32'h1234_5678; rhs = 32'd3;
    lhs_valid = 1'b1; rhs_valid = 1'b1; result_ready = 1'b1;

    // Reset state, with both operands offered while reset is high
    tick();
    tick();
    check("rst_valid", {31'd0, result_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_readies", {30'd0, rhs_ready, lhs_ready}, 32'd0);
    lhs_valid = 1'b0; rhs_valid = 1'b0;
    rst = 1'b0;
    tick();
    check("post_rst_valid", {31'd0, result_valid}, 32'd0);

    run_op("f1_sh4",    32'h0000_00F1, 32'd4,          32'h0000_0F10, 2);
    run_op("sh0",       32'hDEAD_BEEF, 32'd0,          32'hDEAD_BEEF, 1);
    run_op("one_sh31",  32'h0000_0001, 32'd31,         32'h8000_0000, 5);
    run_op("ff_sh9",    32'hFFFF_FFFF, 32'd9,          32'hFFFF_FE00, 3);
    run_op("sh8",       32'h1234_5678, 32'd8,          32'h3456_7800, 2);
    run_op("ff_sh32",   32'hFFFF_FFFF, 32'd32,         32'h0000_0000, 5);
    run_op("ff_sh33",   32'hFFFF_FFFF, 32'd33,         32'h0000_0000, 5);
    run_op("ff_shmax",  32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'h0000_0000, 5);

    // Join: lhs alone is never consumed
    lhs = 32'd5; rhs = 32'd2; lhs_valid = 1'b1; rhs_valid = 1'b0; result_ready = 1'b0;
    #1;
    check("join_lhs_ready", {31'd0, lhs_ready}, 32'd0);
    check("join_rhs_ready", {31'd0, rhs_ready}, 32'd1);
    tick();
    tick();
    check("join_no_accept", {31'd0, result_valid}, 32'd0);
    rhs_valid = 1'b1;
    #1;
    check("join_both_ready", {30'd0, rhs_ready, lhs_ready}, 32'h0000_0003);
    tick();
    lhs = 32'd7; rhs = 32'd1;
    lat = 1;
    while (!result_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("bp_lat", 32'(lat), 32'd2);
    for (int i = 0; i < 10; i++) begin
      check("bp_result", result, 32'd20);
      check("bp_valid", {31'd0, result_valid}, 32'd1);
      check("bp_readies", {30'd0, rhs_ready, lhs_ready}, 32'd0);
      tick();
    end
    result_ready = 1'b1;
    tick();
    check("bp_released", {31'd0, result_valid}, 32'd0);
    check("bp_new_ready", {30'd0, rhs_ready, lhs_ready}, 32'h0000_0003);
    tick();
    lhs_valid = 1'b0; rhs_valid = 1'b0;
    lat = 1;
    while (!result_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("bp_next_lat", 32'(lat), 32'd2);
    check("bp_next_val", result, 32'd14);
    tick();

    // Reset while BUSY drops the operation
    lhs = 32'h0000_ABCD; rhs = 32'd24; lhs_valid = 1'b1; rhs_valid = 1'b1;
    tick();
    lhs_valid = 1'b0; rhs_valid = 1'b0;
    check("busy_no_valid", {31'd0, result_valid}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", {31'd0, result_valid}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("no_stale", {31'd0, result_valid}, 32'd0);
    end
    run_op("after_rst", 32'd3, 32'd1, 32'd6, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
